// File: rtl/hazard_unit_pkg.sv
// Shared constants and types for the hazard unit.
// Forward-select encodings, FSM states and register index width.
package hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-register fields into the hazard unit and its control outputs.
// master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = hazard_unit_pkg::REG_ADDR_W
);

  logic [REG_ADDR_W-1:0] if_id_rs_i;
  logic [REG_ADDR_W-1:0] if_id_rt_i;
  logic [REG_ADDR_W-1:0] id_ex_rs_i;
  logic [REG_ADDR_W-1:0] id_ex_rt_i;
  logic [REG_ADDR_W-1:0] id_ex_rd_i;
  logic                  id_ex_memRead_i;
  logic                  ex_mem_regWrite_i;
  logic                  ex_mem_memRead_i;
  logic [REG_ADDR_W-1:0] ex_mem_rd_i;
  logic                  mem_wb_regWrite_i;
  logic [REG_ADDR_W-1:0] mem_wb_rd_i;
  logic                  branch_taken_i;
  logic                  md_start_i;

  logic [1:0]            forwardA_o;
  logic [1:0]            forwardB_o;
  logic                  pc_stall_o;
  logic                  if_id_stall_o;
  logic                  id_ex_stall_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  md_busy_o;

  modport master (
    output if_id_rs_i, if_id_rt_i,
    output id_ex_rs_i, id_ex_rt_i, id_ex_rd_i,
    output id_ex_memRead_i,
    output ex_mem_regWrite_i, ex_mem_memRead_i,
    output ex_mem_rd_i,
    output mem_wb_regWrite_i, mem_wb_rd_i,
    output branch_taken_i, md_start_i,
    input  forwardA_o, forwardB_o,
    input  pc_stall_o, if_id_stall_o, id_ex_stall_o,
    input  if_id_flush_o, id_ex_flush_o,
    input  md_busy_o
  );

  modport slave (
    input  if_id_rs_i, if_id_rt_i,
    input  id_ex_rs_i, id_ex_rt_i, id_ex_rd_i,
    input  id_ex_memRead_i,
    input  ex_mem_regWrite_i, ex_mem_memRead_i,
    input  ex_mem_rd_i,
    input  mem_wb_regWrite_i, mem_wb_rd_i,
    input  branch_taken_i, md_start_i,
    output forwardA_o, forwardB_o,
    output pc_stall_o, if_id_stall_o, id_ex_stall_o,
    output if_id_flush_o, id_ex_flush_o,
    output md_busy_o
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Single-operand forward selector for the EX-stage operand mux.
// EX/MEM wins over MEM/WB; loads in EX/MEM have no data yet.
module hazard_unit_fwd_sel #(
  parameter int REG_ADDR_W = hazard_unit_pkg::REG_ADDR_W
) (
  input  logic                  en_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  ex_mem_we_i,
  input  logic                  ex_mem_ld_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  mem_wb_we_i,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd_i,
  output logic [1:0]            sel_o
);
  import hazard_unit_pkg::*;

  logic ex_mem_hit;
  logic mem_wb_hit;

  always_comb begin
    ex_mem_hit = ex_mem_we_i && !ex_mem_ld_i &&
                 (ex_mem_rd_i != '0) &&
                 (ex_mem_rd_i == src_i);
    mem_wb_hit = mem_wb_we_i &&
                 (mem_wb_rd_i != '0) &&
                 (mem_wb_rd_i == src_i);
    sel_o = FWD_REGFILE;
    if (en_i) begin
      if (ex_mem_hit)
        sel_o = FWD_EXMEM;
      else if (mem_wb_hit)
        sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects plus stall/flush sequencing for the EX stage.
// `define HAZARD_PERF_EN adds stall-cycle and flush counters.
module hazard_unit #(
  parameter int REG_ADDR_W = hazard_unit_pkg::REG_ADDR_W,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
`ifdef HAZARD_PERF_EN
  output logic [31:0]   stall_cycles_o,
  output logic [15:0]   flush_count_o,
`endif
  hazard_unit_if.slave  hz
);
  import hazard_unit_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  hazard_unit_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .en_i        (!rst_i),
    .src_i       (hz.id_ex_rs_i),
    .ex_mem_we_i (hz.ex_mem_regWrite_i),
    .ex_mem_ld_i (hz.ex_mem_memRead_i),
    .ex_mem_rd_i (hz.ex_mem_rd_i),
    .mem_wb_we_i (hz.mem_wb_regWrite_i),
    .mem_wb_rd_i (hz.mem_wb_rd_i),
    .sel_o       (hz.forwardA_o)
  );

  hazard_unit_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .en_i        (!rst_i),
    .src_i       (hz.id_ex_rt_i),
    .ex_mem_we_i (hz.ex_mem_regWrite_i),
    .ex_mem_ld_i (hz.ex_mem_memRead_i),
    .ex_mem_rd_i (hz.ex_mem_rd_i),
    .mem_wb_we_i (hz.mem_wb_regWrite_i),
    .mem_wb_rd_i (hz.mem_wb_rd_i),
    .sel_o       (hz.forwardB_o)
  );

  always_comb begin
    lu = hz.id_ex_memRead_i &&
         (hz.id_ex_rd_i != '0) &&
         ((hz.id_ex_rd_i == hz.if_id_rs_i) ||
          (hz.id_ex_rd_i == hz.if_id_rt_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loaded with MD_LATENCY-1; leaving when it would hit zero
  // gives exactly MD_LATENCY-1 busy cycles.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    hz.pc_stall_o    = 1'b0;
    hz.if_id_stall_o = 1'b0;
    hz.id_ex_stall_o = 1'b0;
    hz.if_id_flush_o = 1'b0;
    hz.id_ex_flush_o = 1'b0;
    hz.md_busy_o     = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (hz.branch_taken_i) begin
            hz.if_id_flush_o = 1'b1;
            hz.id_ex_flush_o = 1'b1;
          end else if (hz.md_start_i) begin
            state_d = ST_MD_BUSY;
            cnt_d   = CNT_W'(MD_LATENCY - 1);
          end else if (lu) begin
            hz.pc_stall_o    = 1'b1;
            hz.if_id_stall_o = 1'b1;
            hz.id_ex_flush_o = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          hz.pc_stall_o    = 1'b1;
          hz.if_id_stall_o = 1'b1;
          hz.id_ex_stall_o = 1'b1;
          hz.md_busy_o     = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.pc_stall_o && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (hz.if_id_flush_o && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`endif

endmodule
